dsram_arbiter: RTL and testbench
================================

DSRAM_ARBITER -- requirements
Module: dsram_arbiter

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-003 The block SHALL have port m0_req, input, 1 bit: pipeline (EXE-stage) access request.
REQ-004 The block SHALL have port m0_wen, input, 4 bits: pipeline byte write enables; 0 means read.
REQ-005 The block SHALL have ports m0_addr and m0_wdata, input, 32 bits each: pipeline address and write data.
REQ-006 The block SHALL have port m0_gnt, output, 1 bit: pipeline request accepted this cycle.
REQ-007 The block SHALL have port m0_rvalid, output, 1 bit: pipeline read data valid.
REQ-008 The block SHALL have port m0_rdata, output, 32 bits: pipeline read data.
REQ-009 The block SHALL have ports m1_req, m1_wen, m1_addr, m1_wdata, m1_gnt, m1_rvalid and m1_rdata, with the same directions, widths and meanings as the m0 ports, for the DMA/debug requester.
REQ-010 The block SHALL have port data_sram_en, output, 1 bit: SRAM enable.
REQ-011 The block SHALL have port data_sram_wen, output, 4 bits: SRAM byte write enables.
REQ-012 The block SHALL have ports data_sram_addr and data_sram_wdata, output, 32 bits each: SRAM address and write data.
REQ-013 The block SHALL have port data_sram_rdata, input, 32 bits: SRAM read data, valid one cycle after an enabled read.

Function
REQ-014 Arbitration SHALL be combinational: at most one of m0_gnt and m1_gnt is high in any cycle, and mN_gnt is high only when mN_req is high.
REQ-015 A granted request SHALL drive data_sram_en=1 and route that master's wen, addr and wdata to the SRAM in the same cycle.
REQ-016 With no request, data_sram_en SHALL be 0, data_sram_wen SHALL be 0, and addr/wdata SHALL be don't-care.
REQ-017 A requester SHALL hold its req/addr/wen/wdata stable until it sees gnt; the arbiter keeps no request queue.
REQ-018 A granted read (wen==0) SHALL set the registered rd_owner to that master (M0 or M1); a cycle with no read grant SHALL set rd_owner to NONE.
REQ-019 In the cycle after a granted read, mN_rvalid SHALL be 1 for the owning master only, and mN_rdata SHALL equal data_sram_rdata.
REQ-020 A granted write SHALL never produce rvalid.
REQ-021 Back-to-back grants SHALL be allowed every cycle; a read response and a new grant can coincide.
REQ-022 Register last_gnt SHALL record which master was granted most recently and SHALL hold its value in idle cycles.
REQ-023 Simultaneous requests SHALL be resolved per REQ-029; a single requester is always granted immediately.

Reset
REQ-024 While reset is high, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid and data_sram_en SHALL be 0, regardless of req inputs.
REQ-025 Reset SHALL set rd_owner=NONE and last_gnt=M1, so M0 wins the first tie.
REQ-026 Reset asserted in the cycle after a read grant SHALL suppress that rvalid; the read is discarded.
REQ-027 The first grant SHALL occur in the first cycle with reset low.

Configuration
REQ-028 Macro DSRAM_ARB_RR_EN SHALL select the arbitration policy.
REQ-029 With DSRAM_ARB_RR_EN defined, a tie SHALL be granted to the master not in last_gnt (round-robin); without it, a tie SHALL always be granted to M0 (fixed priority) and last_gnt is unused.

Verification
REQ-030 Verification SHALL cover: reset high with m0_req=m1_req=1 -> both gnt=0, data_sram_en=0; first cycle after reset -> m0_gnt=1.
REQ-031 Verification SHALL cover: m0 read of addr 0x100 alone, SRAM returns 0xDEADBEEF -> m0_gnt=1 in cycle T; m0_rvalid=1 with m0_rdata=0xDEADBEEF in T+1; m1_rvalid=0.
REQ-032 Verification SHALL cover: m1 write wen=0xF, addr 0x200, wdata 0x12345678 -> data_sram_wen=0xF, addr=0x200, wdata=0x12345678 in the grant cycle; no rvalid follows.
REQ-033 Verification SHALL cover: both requesting reads for 4 cycles with DSRAM_ARB_RR_EN defined -> grants M0,M1,M0,M1, and each rvalid goes only to the matching master one cycle later.
REQ-034 Verification SHALL cover: both requesting for 4 cycles without DSRAM_ARB_RR_EN -> m0_gnt=1 in all 4 cycles and m1_gnt=0.
REQ-035 Verification SHALL cover: m0 read granted in T and reset asserted in T+1 -> m0_rvalid=0 in T+1.

Source files
------------

// File: rtl/dsram_arbiter.sv
// Two-master data SRAM arbiter: pipeline (m0) and DMA/debug (m1).
// Define DSRAM_ARB_RR_EN for round-robin ties; default is fixed M0 priority.
module dsram_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [3:0]  m0_wen,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic [3:0]  m1_wen,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_wen,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic [31:0] data_sram_rdata
);

    typedef enum logic [1:0] {
        RD_NONE,
        RD_M0,
        RD_M1
    } rd_owner_t;

    rd_owner_t rd_owner;
    rd_owner_t rd_owner_nxt;

`ifdef DSRAM_ARB_RR_EN
    typedef enum logic {
        LAST_M0,
        LAST_M1
    } last_t;

    last_t last_gnt;
    last_t last_gnt_nxt;
`endif

    // Grants are forced low during reset so nothing reaches the SRAM.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!reset) begin
            if (m0_req && m1_req) begin
`ifdef DSRAM_ARB_RR_EN
                if (last_gnt == LAST_M1) begin
                    m0_gnt = 1'b1;
                end else begin
                    m1_gnt = 1'b1;
                end
`else
                m0_gnt = 1'b1;
`endif
            end else begin
                m0_gnt = m0_req;
                m1_gnt = m1_req;
            end
        end
    end

    always_comb begin
        data_sram_en    = m0_gnt | m1_gnt;
        data_sram_wen   = 4'h0;
        data_sram_addr  = m0_addr;
        data_sram_wdata = m0_wdata;
        rd_owner_nxt    = RD_NONE;
        if (m1_gnt) begin
            data_sram_wen   = m1_wen;
            data_sram_addr  = m1_addr;
            data_sram_wdata = m1_wdata;
            if (m1_wen == 4'h0) begin
                rd_owner_nxt = RD_M1;
            end
        end else if (m0_gnt) begin
            data_sram_wen = m0_wen;
            if (m0_wen == 4'h0) begin
                rd_owner_nxt = RD_M0;
            end
        end
    end

`ifdef DSRAM_ARB_RR_EN
    always_comb begin
        last_gnt_nxt = last_gnt;
        if (m0_gnt) begin
            last_gnt_nxt = LAST_M0;
        end else if (m1_gnt) begin
            last_gnt_nxt = LAST_M1;
        end
    end

    // Resetting to M1 lets M0 win the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt <= LAST_M1;
        end else begin
            last_gnt <= last_gnt_nxt;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_owner <= RD_NONE;
        end else begin
            rd_owner <= rd_owner_nxt;
        end
    end

    // A reset arriving right after a read grant discards that response.
    assign m0_rvalid = !reset && (rd_owner == RD_M0);
    assign m1_rvalid = !reset && (rd_owner == RD_M1);
    assign m0_rdata  = data_sram_rdata;
    assign m1_rdata  = data_sram_rdata;

endmodule

// File: tb/tb_dsram_arbiter.sv
// Testbench for dsram_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model of the arbitration rules.
module tb_dsram_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req, m1_req;
    logic [3:0]  m0_wen, m1_wen;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;

    int total = 0;
    int bad   = 0;

    // Model state: who gets read data this cycle (0 none, 1 m0, 2 m1)
    // and which master was granted most recently (0 m0, 1 m1).
    int m_owner = 0;
    int m_last  = 1;
    int exp_g;
    logic exp_rv0, exp_rv1;

    dsram_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's inputs at the falling edge, then derive the
    // model's expected grant and read response for that cycle.
    task automatic cycle(input logic r,
                         input logic q0, input logic [3:0] w0,
                         input logic [31:0] a0, input logic [31:0] d0,
                         input logic q1, input logic [3:0] w1,
                         input logic [31:0] a1, input logic [31:0] d1,
                         input logic [31:0] rd);
        @(negedge clk);
        reset = r;
        m0_req = q0; m0_wen = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = q1; m1_wen = w1; m1_addr = a1; m1_wdata = d1;
        data_sram_rdata = rd;
        #1;
        exp_g = 0;
        if (!r) begin
            if (q0 && q1) begin
`ifdef DSRAM_ARB_RR_EN
                exp_g = (m_last == 1) ? 1 : 2;
`else
                exp_g = 1;
`endif
            end else if (q0) begin
                exp_g = 1;
            end else if (q1) begin
                exp_g = 2;
            end
        end
        exp_rv0 = !r && (m_owner == 1);
        exp_rv1 = !r && (m_owner == 2);
    endtask

    // Advance the model past the current cycle.
    task automatic commit();
        if (reset) begin
            m_owner = 0;
            m_last  = 1;
        end else if (exp_g == 1) begin
            m_owner = (m0_wen == 4'h0) ? 1 : 0;
            m_last  = 0;
        end else if (exp_g == 2) begin
            m_owner = (m1_wen == 4'h0) ? 2 : 0;
            m_last  = 1;
        end else begin
            m_owner = 0;
        end
    endtask

    task automatic idle(input logic r);
        cycle(r, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 32'h0);
        commit();
    endtask

    task automatic test_reset();
        cycle(1, 1, 4'h0, 32'h10, 0, 1, 4'h0, 32'h20, 0, 32'h0);
        total++;
        if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
            bad++;
            $display("FAIL reset_gnt got=%b%b want=00", m0_gnt, m1_gnt);
        end
        total++;
        if (data_sram_en !== 1'b0 || m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL reset_en_rv got en=%b rv=%b%b want 0",
                     data_sram_en, m0_rvalid, m1_rvalid);
        end
        commit();
        cycle(0, 1, 4'h0, 32'h10, 0, 1, 4'h0, 32'h20, 0, 32'h0);
        total++;
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || data_sram_en !== 1'b1) begin
            bad++;
            $display("FAIL first_gnt got=%b%b en=%b want=10 en=1",
                     m0_gnt, m1_gnt, data_sram_en);
        end
        commit();
        idle(0);
    endtask

    task automatic test_m0_read();
        cycle(0, 1, 4'h0, 32'h100, 32'h0, 0, 4'h0, 0, 0, 32'h0);
        total++;
        if (m0_gnt !== 1'b1 || data_sram_addr !== 32'h100 ||
            data_sram_wen !== 4'h0 || data_sram_en !== 1'b1) begin
            bad++;
            $display("FAIL m0_read_gnt got gnt=%b addr=%h wen=%h want 1 100 0",
                     m0_gnt, data_sram_addr, data_sram_wen);
        end
        commit();
        cycle(0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 32'hDEADBEEF);
        total++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF || m1_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL m0_read_resp got rv0=%b rd=%h rv1=%b want 1 deadbeef 0",
                     m0_rvalid, m0_rdata, m1_rvalid);
        end
        commit();
    endtask

    task automatic test_m1_write();
        cycle(0, 0, 4'h0, 0, 0, 1, 4'hF, 32'h200, 32'h12345678, 32'h0);
        total++;
        if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0 || data_sram_wen !== 4'hF ||
            data_sram_addr !== 32'h200 || data_sram_wdata !== 32'h12345678) begin
            bad++;
            $display("FAIL m1_write got gnt=%b wen=%h addr=%h wd=%h want 1 f 200 12345678",
                     m1_gnt, data_sram_wen, data_sram_addr, data_sram_wdata);
        end
        commit();
        cycle(0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 32'hCAFE0000);
        total++;
        if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL m1_write_norv got rv=%b%b want=00", m0_rvalid, m1_rvalid);
        end
        commit();
    endtask

    task automatic test_tie();
        int want [4];
        int prev;
`ifdef DSRAM_ARB_RR_EN
        want = '{1, 2, 1, 2};
`else
        want = '{1, 1, 1, 1};
`endif
        idle(1);
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                cycle(0, 1, 4'h0, 32'h300 + i, 0, 1, 4'h0, 32'h400 + i, 0, 32'hA000 + i);
                total++;
                if (m0_gnt !== (want[i] == 1) || m1_gnt !== (want[i] == 2)) begin
                    bad++;
                    $display("FAIL tie_gnt%0d got=%b%b want_master=%0d",
                             i, m0_gnt, m1_gnt, want[i]);
                end
            end else begin
                cycle(0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 32'hA000 + i);
            end
            if (i > 0) begin
                total++;
                if (m0_rvalid !== (prev == 1) || m1_rvalid !== (prev == 2) ||
                    data_sram_rdata !== (32'hA000 + i)) begin
                    bad++;
                    $display("FAIL tie_rv%0d got=%b%b want_master=%0d",
                             i, m0_rvalid, m1_rvalid, prev);
                end
            end
            prev = (i < 4) ? want[i] : 0;
            commit();
        end
    endtask

    task automatic test_reset_discard();
        cycle(0, 1, 4'h0, 32'h500, 0, 0, 4'h0, 0, 0, 32'h0);
        total++;
        if (m0_gnt !== 1'b1) begin
            bad++;
            $display("FAIL discard_gnt got=%b want=1", m0_gnt);
        end
        commit();
        cycle(1, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 32'h55AA55AA);
        total++;
        if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL discard_rv got=%b%b want=00", m0_rvalid, m1_rvalid);
        end
        commit();
        idle(0);
    endtask

    task automatic test_random();
        logic r, q0, q1;
        logic [3:0] w0, w1;
        logic [31:0] a0, a1, d0, d1, rd;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 24) == 0);
            q0 = $urandom_range(0, 1);
            q1 = $urandom_range(0, 1);
            w0 = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
            w1 = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
            a0 = $urandom; a1 = $urandom;
            d0 = $urandom; d1 = $urandom;
            rd = $urandom;
            cycle(r, q0, w0, a0, d0, q1, w1, a1, d1, rd);
            total++;
            if (m0_gnt !== (exp_g == 1) || m1_gnt !== (exp_g == 2) ||
                data_sram_en !== (exp_g != 0)) begin
                bad++;
                $display("FAIL rnd_gnt%0d got=%b%b en=%b want_master=%0d",
                         i, m0_gnt, m1_gnt, data_sram_en, exp_g);
            end
            total++;
            if (exp_g == 1 && {data_sram_wen, data_sram_addr, data_sram_wdata} !== {w0, a0, d0} ||
                exp_g == 2 && {data_sram_wen, data_sram_addr, data_sram_wdata} !== {w1, a1, d1} ||
                exp_g == 0 && data_sram_wen !== 4'h0) begin
                bad++;
                $display("FAIL rnd_route%0d got wen=%h addr=%h wd=%h master=%0d",
                         i, data_sram_wen, data_sram_addr, data_sram_wdata, exp_g);
            end
            total++;
            if (m0_rvalid !== exp_rv0 || m1_rvalid !== exp_rv1 ||
                (exp_rv0 && m0_rdata !== rd) || (exp_rv1 && m1_rdata !== rd)) begin
                bad++;
                $display("FAIL rnd_rv%0d got=%b%b want=%b%b rd0=%h rd1=%h sram=%h",
                         i, m0_rvalid, m1_rvalid, exp_rv0, exp_rv1, m0_rdata, m1_rdata, rd);
            end
            commit();
        end
    endtask

    initial begin
        reset = 1'b1;
        m0_req = 0; m0_wen = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_wen = 0; m1_addr = 0; m1_wdata = 0;
        data_sram_rdata = 0;
        test_reset();
        test_m0_read();
        test_m1_write();
        test_tie();
        test_reset_discard();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
